// File: rtl/mmss_timer_pkg.sv
// Shared types, constants and BCD helpers for the mm:ss countdown timer.
// Latency: n/a (declarations only); backpressure: n/a.
package mmss_timer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [7:0] BCD_ZERO = 8'h00;
   localparam logic [7:0] SEC_WRAP = 8'h59;

   function automatic logic bcd_ok(input logic [7:0] v);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
   endfunction

   function automatic int bcd_to_int(input logic [7:0] v);
      return 10 * int'(v[7:4]) + int'(v[3:0]);
   endfunction

endpackage

// File: rtl/mmss_timer_bcd_pair_dec.sv
// Two-digit BCD decrement with borrow chain; 00 with borrow wraps to WRAP.
// Latency: combinational; backpressure: none.
module bcd_pair_dec
   import mmss_timer_pkg::*;
#(
   parameter logic [7:0] WRAP = SEC_WRAP
) (
   input  logic [7:0] val,
   input  logic       borrow_in,
   output logic [7:0] result,
   output logic       borrow_out
);

   always_comb begin
      result     = val;
      borrow_out = 1'b0;
      if (borrow_in) begin
         if (val == BCD_ZERO) begin
            result     = WRAP;
            borrow_out = 1'b1;
         end else if (val[3:0] == 4'd0) begin
            result = {val[7:4] - 4'd1, 4'd9};
         end else begin
            result = {val[7:4], val[3:0] - 4'd1};
         end
      end
   end

endmodule

// File: rtl/mmss_timer.sv
// BCD mm:ss countdown timer with load/start/pause and one-shot expiry pulse.
// Latency: every output updates on the edge that samples tick/load; no backpressure.
module mmss_timer
   import mmss_timer_pkg::*;
#(
   parameter int MAX_MIN = 59
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       load,
   input  logic [7:0] set_min,
   input  logic [7:0] set_sec,
   input  logic       start,
   input  logic       pause,
   output logic [7:0] min_bcd,
   output logic [7:0] sec_bcd,
   output logic       running,
   output logic       done,
   output logic       expired,
   output logic       load_err
);

   state_t     state, state_nx;
   logic [7:0] min_nx, sec_nx;
   logic       load_err_nx;

   logic [7:0] sec_dec, min_dec;
   logic       sec_borrow, min_borrow;
   logic       dec_en, dec_ok, dec_zero, count_zero, load_valid;

   assign dec_en = (state == RUN) && tick;

   bcd_pair_dec #(.WRAP(SEC_WRAP)) u_sec_dec (
      .val        (sec_bcd),
      .borrow_in  (dec_en),
      .result     (sec_dec),
      .borrow_out (sec_borrow)
   );

   bcd_pair_dec #(.WRAP(8'h99)) u_min_dec (
      .val        (min_bcd),
      .borrow_in  (sec_borrow),
      .result     (min_dec),
      .borrow_out (min_borrow)
   );

   // A borrow out of the minutes pair means the count was 00:00: hold instead of wrapping.
   assign dec_ok     = dec_en && !min_borrow;
   assign dec_zero   = (min_dec == BCD_ZERO) && (sec_dec == BCD_ZERO);
   assign count_zero = (min_bcd == BCD_ZERO) && (sec_bcd == BCD_ZERO);
   assign load_valid = bcd_ok(set_min) && bcd_ok(set_sec) &&
                       (set_sec[7:4] <= 4'd5) &&
                       (bcd_to_int(set_min) <= MAX_MIN);

   always_comb begin
      state_nx    = state;
      min_nx      = min_bcd;
      sec_nx      = sec_bcd;
      load_err_nx = 1'b0;
      case (state)
         IDLE: begin
            if (load) begin
               if (load_valid) begin
                  min_nx = set_min;
                  sec_nx = set_sec;
               end else begin
                  load_err_nx = 1'b1;
               end
            end else if (start && !count_zero) begin
               state_nx = RUN;
            end
         end
         RUN: begin
            if (dec_ok) begin
               min_nx = min_dec;
               sec_nx = sec_dec;
            end
            if (dec_ok && dec_zero) begin
               state_nx = DONE;
            end else if (pause) begin
               state_nx = PAUSE;
            end
         end
         PAUSE, DONE: begin
            if (load) begin
               if (load_valid) begin
                  min_nx   = set_min;
                  sec_nx   = set_sec;
                  state_nx = IDLE;
               end else begin
                  load_err_nx = 1'b1;
               end
            end else if (state == PAUSE && start && !pause) begin
               state_nx = RUN;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         min_bcd  <= BCD_ZERO;
         sec_bcd  <= BCD_ZERO;
         running  <= 1'b0;
         done     <= 1'b0;
         expired  <= 1'b0;
         load_err <= 1'b0;
      end else begin
         state    <= state_nx;
         min_bcd  <= min_nx;
         sec_bcd  <= sec_nx;
         running  <= (state_nx == RUN);
         done     <= (state_nx == DONE);
         expired  <= (state_nx == DONE) && (state != DONE);
         load_err <= load_err_nx;
      end
   end

endmodule

// File: doc/mmss_timer.md
MMSS_TIMER -- requirements
Module: mmss_timer

Interface
REQ-001 SHALL have parameter MAX_MIN, default 59, the largest loadable minutes value (BCD-checked, 0..99).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port tick  input  1  one-clk-wide 1 Hz strobe from the upstream divider.
REQ-005 SHALL have port load  input  1  capture set_min/set_sec this cycle.
REQ-006 SHALL have port set_min  input  8  BCD minutes, {tens, ones}.
REQ-007 SHALL have port set_sec  input  8  BCD seconds, {tens, ones}.
REQ-008 SHALL have port start  input  1  begin or resume the countdown.
REQ-009 SHALL have port pause  input  1  freeze the countdown.
REQ-010 SHALL have port min_bcd  output  8  current BCD minutes.
REQ-011 SHALL have port sec_bcd  output  8  current BCD seconds.
REQ-012 SHALL have port running  output  1  high while in RUN.
REQ-013 SHALL have port done  output  1  high while in DONE.
REQ-014 SHALL have port expired  output  1  one-clk pulse on entry to DONE.
REQ-015 SHALL have port load_err  output  1  one-clk pulse when a load is rejected.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, PAUSE, DONE; all outputs registered.
REQ-017 IDLE: load with valid value -> count := value, stay IDLE; start with count != 00:00 -> RUN; start with count == 00:00 -> stay IDLE.
REQ-018 RUN: each tick decrements count by one second; pause -> PAUSE; load ignored.
REQ-019 RUN: tick while count == 00:01 -> count 00:00, next state DONE, expired high for exactly the first DONE cycle.
REQ-020 PAUSE: tick ignored; start -> RUN; valid load -> count := value, IDLE.
REQ-021 DONE: start, pause and tick ignored; valid load -> count := value, IDLE, done low next cycle.
REQ-022 Valid load: each digit <= 9, seconds tens <= 5, minutes <= MAX_MIN; otherwise count and state unchanged and load_err pulses one cycle after the load edge.
REQ-023 Decrement: seconds ones 0 -> 9 with borrow into seconds tens; seconds 00 -> 59 with borrow into minutes; minutes BCD-decremented likewise; 00:00 never decremented (no wrap to 99:59).
REQ-024 Priority on the same cycle: load > pause > start; in RUN, tick together with pause applies the decrement, then enters PAUSE.
REQ-025 Latency: min_bcd/sec_bcd reflect a tick or load on the clk edge that samples it (one-cycle registered update).
REQ-026 Tick pulses wider than one clk SHALL decrement once per clk cycle they are high (no edge detection inside the block).

Reset
REQ-027 Reset low SHALL immediately force state IDLE, min_bcd = 8'h00, sec_bcd = 8'h00, running = 0, done = 0, expired = 0, load_err = 0.
REQ-028 Reset asserted mid-countdown SHALL abandon the count; after release the block waits in IDLE for load.
REQ-029 Release of reset SHALL take effect at the first rising clk edge after reset goes high; no input is acted on at the release edge itself.

Structure
REQ-030 A shared package SHALL hold the state enum (IDLE, RUN, PAUSE, DONE) and constants BCD_ZERO = 8'h00 and SEC_WRAP = 8'h59.
REQ-031 Two-digit BCD decrement with borrow-in/borrow-out and a parameterized wrap value SHALL be a sub-module named bcd_pair_dec, instantiated twice (seconds, minutes).
REQ-032 Block SHALL contain no clock divider; tick comes from the upstream 1 Hz strobe generator.

Verification
REQ-033 Load 00:03, start, 3 ticks -> counts 00:02, 00:01, 00:00; expired pulses one clk; done stays high.
REQ-034 Load 01:00, start, 1 tick -> 00:59; load 10:00, start, 1 tick -> 09:59.
REQ-035 Load set_sec = 8'h60 -> load_err pulse, count unchanged; load set_min = 8'h1A -> load_err pulse.
REQ-036 RUN at 00:05, pause with tick on the same cycle -> 00:04 and PAUSE; further ticks -> no change; start, 1 tick -> 00:03.
REQ-037 Start with count 00:00 in IDLE -> running stays 0; load 00:02 and start on the same cycle -> count 00:02, stays IDLE.
REQ-038 Reset low during RUN at 00:30 -> outputs zero at once, IDLE; ticks after release -> no change.
